// File: rtl/cdb_pkg.sv
// Shared types and constants for the Common Data Bus transmitter.
// cdb_msg_t is the default payload carried from a functional unit to the CDB.
package cdb_pkg;

  localparam int CDB_TAG_W  = 5;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] value;
  } cdb_msg_t;

  // ROB tag 0 means "no dependency" and must never be broadcast
  localparam logic [CDB_TAG_W-1:0] TAG_NONE = '0;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result queue: DEPTH-entry FIFO with combinational head,
// synchronous flush clear and asynchronous reset.
module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type msg_t = cdb_msg_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  msg_t                     push_msg,
  input  logic                     pop,
  output msg_t                     head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  msg_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_msg;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmitter: queues FU results per source, picks one per cycle by
// round-robin and broadcasts it from registers.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 2,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          fu_valid,
  input  logic [NUM_SRC*TAG_W-1:0]    fu_tag,
  input  logic [NUM_SRC*DATA_W-1:0]   fu_value,
  output logic [NUM_SRC-1:0]          fu_ready,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_value,
  output logic [$clog2(NUM_SRC)-1:0]  cdb_src,
  output logic                        err_tag0
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } msg_t;

  msg_t               head [NUM_SRC];
  logic [CNT_W-1:0]   count [NUM_SRC];
  logic [NUM_SRC-1:0] push, pop, nonempty, tag0_hit;

  logic               grant_valid;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   rr_ptr_reg, rr_ptr_next;

  logic               cdb_valid_reg;
  logic [TAG_W-1:0]   cdb_tag_reg;
  logic [DATA_W-1:0]  cdb_value_reg;
  logic [SRC_W-1:0]   cdb_src_reg;
  logic               err_tag0_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [TAG_W-1:0] src_tag;
      logic             accept;
      msg_t             src_msg;

      assign src_tag       = fu_tag[gi*TAG_W +: TAG_W];
      assign src_msg.tag   = src_tag;
      assign src_msg.value = fu_value[gi*DATA_W +: DATA_W];

      // Ready reflects stored occupancy only, so a full queue stalls its source
      assign fu_ready[gi] = (count[gi] < CNT_W'(DEPTH));
      assign nonempty[gi] = (count[gi] != '0);
      assign accept       = fu_valid[gi] && fu_ready[gi] && !flush;
      assign push[gi]     = accept && (src_tag != TAG_W'(TAG_NONE));
      assign tag0_hit[gi] = accept && (src_tag == TAG_W'(TAG_NONE));
      assign pop[gi]      = grant_valid && (grant_idx == SRC_W'(gi));

      cdb_src_fifo #(
        .DEPTH (DEPTH),
        .msg_t (msg_t)
      ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push[gi]),
        .push_msg (src_msg),
        .pop      (pop[gi]),
        .head     (head[gi]),
        .count    (count[gi])
      );
    end
  endgenerate

  // First non-empty queue at or after rr_ptr, wrapping
  always_comb begin
    int               idx;
    logic [SRC_W-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    cand        = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      cand = SRC_W'(idx);
      if (!grant_valid && nonempty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    if (flush) grant_valid = 1'b0;
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (flush) begin
      rr_ptr_next = '0;
    end else if (grant_valid) begin
      if (grant_idx == SRC_W'(NUM_SRC - 1)) rr_ptr_next = '0;
      else                                  rr_ptr_next = grant_idx + SRC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg    <= '0;
      cdb_valid_reg <= 1'b0;
      cdb_tag_reg   <= '0;
      cdb_value_reg <= '0;
      cdb_src_reg   <= '0;
      err_tag0_reg  <= 1'b0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      if (|tag0_hit) err_tag0_reg <= 1'b1;
      if (grant_valid) begin
        cdb_valid_reg <= 1'b1;
        cdb_tag_reg   <= head[grant_idx].tag;
        cdb_value_reg <= head[grant_idx].value;
        cdb_src_reg   <= grant_idx;
      end else begin
        // payload holds its last value when idle
        cdb_valid_reg <= 1'b0;
      end
    end
  end

  assign cdb_valid = cdb_valid_reg;
  assign cdb_tag   = cdb_tag_reg;
  assign cdb_value = cdb_value_reg;
  assign cdb_src   = cdb_src_reg;
  assign err_tag0  = err_tag0_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a queue-based
// reference model of the broadcast rules.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int D  = 2;
  localparam int TW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst, flush;
  logic [N-1:0]    fu_valid, fu_ready;
  logic [N*TW-1:0] fu_tag;
  logic [N*DW-1:0] fu_value;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_value;
  logic [1:0]      cdb_src;
  logic            err_tag0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_SRC(N), .DEPTH(D), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_tag    (fu_tag),
    .fu_value  (fu_value),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .cdb_src   (cdb_src),
    .err_tag0  (err_tag0)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [TW+DW-1:0] mq [N][$];
  int               m_rr;
  logic             m_valid;
  logic [TW-1:0]    m_tag;
  logic [DW-1:0]    m_value;
  logic [1:0]       m_src;
  logic             m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_rr = 0; m_valid = 1'b0; m_tag = '0; m_value = '0; m_src = '0; m_err = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict, take the edge, compare.
  task automatic step(input logic [N-1:0] v, input logic [N*TW-1:0] tg,
                      input logic [N*DW-1:0] vl, input logic fl);
    logic [N-1:0]     rdy;
    logic [TW+DW-1:0] m;
    logic [TW-1:0]    t;
    int               g;
    fu_valid = v; fu_tag = tg; fu_value = vl; flush = fl;
    for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < D);
    check("fu_ready", 64'(fu_ready), 64'(rdy));
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && mq[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
    if (fl) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr = 0;
      m_valid = 1'b0;
    end else begin
      if (g >= 0) begin
        m = mq[g].pop_front();
        m_valid = 1'b1;
        m_tag   = m[TW+DW-1:DW];
        m_value = m[DW-1:0];
        m_src   = 2'(g);
        m_rr    = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        t = tg[i*TW +: TW];
        if (v[i] && rdy[i]) begin
          if (t == 0) m_err = 1'b1;
          else mq[i].push_back({t, vl[i*DW +: DW]});
        end
      end
    end
    @(posedge clk);
    #1;
    check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    check("cdb_tag",   64'(cdb_tag),   64'(m_tag));
    check("cdb_value", 64'(cdb_value), 64'(m_value));
    check("cdb_src",   64'(cdb_src),   64'(m_src));
    check("err_tag0",  64'(err_tag0),  64'(m_err));
    if (cdb_valid) $display("bcast src=%0d tag=%0d value=%08h", cdb_src, cdb_tag, cdb_value);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [N*TW-1:0] tg;
    logic [N*DW-1:0] vl;

    rst = 1'b1; flush = 1'b0; fu_valid = '0; fu_tag = '0; fu_value = '0;
    model_reset();
    #12;
    check("rst_ready", 64'(fu_ready), 64'hf);
    check("rst_valid", 64'(cdb_valid), 64'h0);
    check("rst_err",   64'(err_tag0), 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single source: src 2, tag 7
    tg = '0; vl = '0;
    tg[2*TW +: TW] = 5'd7; vl[2*DW +: DW] = 32'hDEADBEEF;
    step(4'b0100, tg, vl, 1'b0);
    check("single_early", 64'(cdb_valid), 64'h0);
    idle(1);
    check("single_valid", 64'(cdb_valid), 64'h1);
    check("single_tag",   64'(cdb_tag),   64'd7);
    check("single_value", 64'(cdb_value), 64'hDEADBEEF);
    check("single_src",   64'(cdb_src),   64'd2);
    idle(1);
    check("single_once",  64'(cdb_valid), 64'h0);

    // Contention from rr_ptr = 0
    step('0, '0, '0, 1'b1);
    for (int i = 0; i < N; i++) begin
      tg[i*TW +: TW] = 5'(i + 1); vl[i*DW +: DW] = 32'h1000 + 32'(i);
    end
    step(4'hf, tg, vl, 1'b0);
    for (int k = 0; k < N; k++) begin
      idle(1);
      check("cont_tag", 64'(cdb_tag), 64'(k + 1));
    end
    idle(1);
    check("cont_done", 64'(cdb_valid), 64'h0);

    // Backpressure: every source offers every cycle
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++) begin
        tg[i*TW +: TW] = 5'((c * N + i) % 31 + 1); vl[i*DW +: DW] = $urandom;
      end
      step(4'hf, tg, vl, 1'b0);
    end
    idle(10);

    // Flush with queued results and a concurrent offer
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) begin
        tg[i*TW +: TW] = 5'(10 + c * N + i); vl[i*DW +: DW] = $urandom;
      end
      step(4'hf, tg, vl, 1'b0);
    end
    step(4'hf, tg, vl, 1'b1);
    check("flush_ready", 64'(fu_ready), 64'hf);
    idle(3);

    // Tag 0 is dropped and sticks through flush
    tg = '0;
    step(4'b0010, tg, vl, 1'b0);
    idle(1);
    check("tag0_err", 64'(err_tag0), 64'h1);
    step('0, '0, '0, 1'b1);
    check("tag0_sticky", 64'(err_tag0), 64'h1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < N; i++) begin
      tg[i*TW +: TW] = 5'(20 + i); vl[i*DW +: DW] = $urandom;
    end
    step(4'b0111, tg, vl, 1'b0);
    fu_valid = '0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(cdb_valid), 64'h0);
    check("arst_tag",   64'(cdb_tag),   64'h0);
    check("arst_value", 64'(cdb_value), 64'h0);
    check("arst_src",   64'(cdb_src),   64'h0);
    check("arst_err",   64'(err_tag0),  64'h0);
    check("arst_ready", 64'(fu_ready),  64'hf);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    idle(1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        tg[i*TW +: TW] = 5'($urandom_range(0, 31)); vl[i*DW +: DW] = $urandom;
      end
      step(4'($urandom_range(0, 15)), tg, vl, ($urandom_range(0, 19) == 0));
    end
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
